// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the read-data path into the reorder buffer.
//   R_*_WIDTH : default field widths of an AXI R beat
//   r_beat_t  : packed R beat {id, data, resp, last, tagid} at default widths
package rob_pkg;

  localparam int R_ID_WIDTH   = 4;
  localparam int R_DATA_WIDTH = 64;
  localparam int R_RESP_WIDTH = 2;
  localparam int R_TAG_WIDTH  = 4;

  typedef struct packed {
    logic [R_ID_WIDTH-1:0]   id;
    logic [R_DATA_WIDTH-1:0] data;
    logic [R_RESP_WIDTH-1:0] resp;
    logic                    last;
    logic [R_TAG_WIDTH-1:0]  tagid;
  } r_beat_t;

endpackage

// File: rtl/r_beat_fifo.sv
// r_beat_fifo: circular buffer of AXI R beats between the R-channel source and
// the reorder buffer. With PACKET_MODE=1, beats are held back until a complete
// burst is stored, or until the buffer is full.
//   clk, rst                          clock, asynchronous active-high reset
//   s_valid/s_ready + s_* fields      input beat handshake and payload
//   m_valid/m_ready + m_* fields      head beat handshake and payload
//   count                             beats currently stored
//   bursts                            stored beats carrying last (complete bursts)
module r_beat_fifo
  import rob_pkg::*;
#(
  parameter int ID_WIDTH    = R_ID_WIDTH,
  parameter int DATA_WIDTH  = R_DATA_WIDTH,
  parameter int RESP_WIDTH  = R_RESP_WIDTH,
  parameter int TAG_WIDTH   = R_TAG_WIDTH,
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = 0,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [RESP_WIDTH-1:0] s_resp,
  input  logic                  s_last,
  input  logic [TAG_WIDTH-1:0]  s_tagid,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [RESP_WIDTH-1:0] m_resp,
  output logic                  m_last,
  output logic [TAG_WIDTH-1:0]  m_tagid,
  input  logic                  m_ready,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         bursts
);

  // Same layout as rob_pkg::r_beat_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic [TAG_WIDTH-1:0]  tagid;
  } beat_t;

  beat_t           mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   bursts_q, bursts_d;
  beat_t           head_s;
  beat_t           in_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;

  assign head_s = mem_q[rd_ptr_q];
  assign in_s   = '{id: s_id, data: s_data, resp: s_resp, last: s_last, tagid: s_tagid};
  assign full_s = (count_q == CW'(DEPTH));

  // Readiness depends only on stored state, so there is no path from m_ready.
  assign s_ready = !rst && !full_s;

  // The full override lets a burst longer than DEPTH drain instead of deadlocking.
  assign m_valid = (count_q != '0) &&
                   ((PACKET_MODE == 0) || (bursts_q != '0) || full_s);

  assign push_s  = s_valid && s_ready;
  assign pop_s   = m_valid && m_ready;

  assign m_id    = head_s.id;
  assign m_data  = head_s.data;
  assign m_resp  = head_s.resp;
  assign m_last  = head_s.last;
  assign m_tagid = head_s.tagid;
  assign count   = count_q;
  assign bursts  = bursts_q;

  // Next-state for pointers, occupancy and complete-burst tally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bursts_d = bursts_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({push_s && s_last, pop_s && head_s.last})
      2'b10:   bursts_d = bursts_q + CW'(1);
      2'b01:   bursts_d = bursts_q - CW'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bursts_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bursts_q <= bursts_d;
    end
  end

  // Beat storage; cleared on reset so the idle head reads as all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_s;
    end
  end

endmodule

// File: tb/tb_r_beat_fifo.sv
module tb_r_beat_fifo;

  logic        clk = 1'b0;
  logic        rst;

  // Instance 0: cut-through, instance 1: packet mode. Both DEPTH=4.
  logic        s0_valid, s0_last, s0_ready, m0_valid, m0_last, m0_ready;
  logic [3:0]  s0_id, s0_tagid, m0_id, m0_tagid;
  logic [63:0] s0_data, m0_data;
  logic [1:0]  s0_resp, m0_resp;
  logic [2:0]  count0, bursts0;

  logic        s1_valid, s1_last, s1_ready, m1_valid, m1_last, m1_ready;
  logic [3:0]  s1_id, s1_tagid, m1_id, m1_tagid;
  logic [63:0] s1_data, m1_data;
  logic [1:0]  s1_resp, m1_resp;
  logic [2:0]  count1, bursts1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r_beat_fifo #(.DEPTH(4), .PACKET_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_valid(s0_valid), .s_id(s0_id), .s_data(s0_data), .s_resp(s0_resp),
    .s_last(s0_last), .s_tagid(s0_tagid), .s_ready(s0_ready),
    .m_valid(m0_valid), .m_id(m0_id), .m_data(m0_data), .m_resp(m0_resp),
    .m_last(m0_last), .m_tagid(m0_tagid), .m_ready(m0_ready),
    .count(count0), .bursts(bursts0)
  );

  r_beat_fifo #(.DEPTH(4), .PACKET_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s1_valid), .s_id(s1_id), .s_data(s1_data), .s_resp(s1_resp),
    .s_last(s1_last), .s_tagid(s1_tagid), .s_ready(s1_ready),
    .m_valid(m1_valid), .m_id(m1_id), .m_data(m1_data), .m_resp(m1_resp),
    .m_last(m1_last), .m_tagid(m1_tagid), .m_ready(m1_ready),
    .count(count1), .bursts(bursts1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int in_idx;
  int out_idx;
  logic do_push;
  logic do_pop;

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0; s0_id = 4'd0; s0_data = 64'd0; s0_resp = 2'd0; s0_last = 1'b0; s0_tagid = 4'd0; m0_ready = 1'b0;
    s1_valid = 1'b0; s1_id = 4'd0; s1_data = 64'd0; s1_resp = 2'd0; s1_last = 1'b0; s1_tagid = 4'd0; m1_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_s_ready", {63'd0, s0_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m0_valid}, 64'd0);
    check("rst_count", {61'd0, count0}, 64'd0);
    check("rst_m_data", m0_data, 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_s_ready0", {63'd0, s0_ready}, 64'd1);
    check("post_rst_s_ready1", {63'd0, s1_ready}, 64'd1);

    // Fill with consumer stalled
    for (int i = 1; i <= 4; i++) begin
      s0_valid = 1'b1; s0_tagid = 4'(i); s0_data = 64'(i); s0_id = 4'(i); s0_resp = 2'(i);
      step();
    end
    s0_valid = 1'b0;
    check("fill_count", {61'd0, count0}, 64'd4);
    check("fill_s_ready", {63'd0, s0_ready}, 64'd0);
    check("fill_m_valid", {63'd0, m0_valid}, 64'd1);
    check("fill_tag", {60'd0, m0_tagid}, 64'd1);
    step(); step();
    check("fill_tag_stable", {60'd0, m0_tagid}, 64'd1);
    check("fill_resp", {62'd0, m0_resp}, 64'd1);

    // Full with pop and s_valid: push only accepted the following cycle
    m0_ready = 1'b1; s0_valid = 1'b1; s0_tagid = 4'd5; s0_data = 64'd5;
    step();
    check("full_pop_count", {61'd0, count0}, 64'd3);
    check("full_pop_s_ready", {63'd0, s0_ready}, 64'd1);
    check("full_pop_head", {60'd0, m0_tagid}, 64'd2);
    m0_ready = 1'b0;
    step();
    s0_valid = 1'b0;
    check("full_push_late", {61'd0, count0}, 64'd4);
    for (int k = 2; k <= 5; k++) begin
      check("drain_tag", {60'd0, m0_tagid}, 64'(k));
      m0_ready = 1'b1;
      step();
    end
    check("drain_count", {61'd0, count0}, 64'd0);
    check("drain_m_valid", {63'd0, m0_valid}, 64'd0);

    // Streaming with consumer always ready
    m0_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s0_valid = 1'b1; s0_data = 64'(i); s0_tagid = 4'(i);
      step();
      check("stream_valid", {63'd0, m0_valid}, 64'd1);
      check("stream_data", m0_data, 64'(i));
      check("stream_count", {61'd0, count0}, 64'd1);
    end
    s0_valid = 1'b0;
    step();
    check("stream_end_count", {61'd0, count0}, 64'd0);
    m0_ready = 1'b0;

    // Packet mode: 3-beat burst held until last beat
    m1_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s1_valid = 1'b1; s1_tagid = 4'(i); s1_data = 64'(8'hA0 + i); s1_last = (i == 3);
      step();
      if (i < 3) check("pkt_hold", {63'd0, m1_valid}, 64'd0);
    end
    s1_valid = 1'b0; s1_last = 1'b0;
    check("pkt_valid", {63'd0, m1_valid}, 64'd1);
    check("pkt_bursts", {61'd0, bursts1}, 64'd1);
    check("pkt_count", {61'd0, count1}, 64'd3);
    check("pkt_tag1", {60'd0, m1_tagid}, 64'd1);
    step();
    check("pkt_tag2", {60'd0, m1_tagid}, 64'd2);
    step();
    check("pkt_tag3", {60'd0, m1_tagid}, 64'd3);
    check("pkt_last", {63'd0, m1_last}, 64'd1);
    step();
    check("pkt_bursts_end", {61'd0, bursts1}, 64'd0);
    check("pkt_count_end", {61'd0, count1}, 64'd0);
    check("pkt_valid_end", {63'd0, m1_valid}, 64'd0);

    // Long burst override: 6 beats, DEPTH=4
    m1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1_valid = 1'b1; s1_tagid = 4'(i); s1_last = 1'b0;
      step();
    end
    check("long_count", {61'd0, count1}, 64'd4);
    check("long_bursts", {61'd0, bursts1}, 64'd0);
    check("long_valid", {63'd0, m1_valid}, 64'd1);
    in_idx = 4;
    out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
      s1_valid = (in_idx < 6); s1_tagid = 4'(in_idx); s1_last = (in_idx == 5);
      m1_ready = 1'b1;
      do_push = s1_valid && s1_ready;
      do_pop  = m1_valid && m1_ready;
      if (do_pop) begin
        check("long_order", {60'd0, m1_tagid}, 64'(out_idx));
        out_idx++;
      end
      step();
      if (do_push) in_idx++;
    end
    s1_valid = 1'b0; s1_last = 1'b0;
    check("long_delivered", 64'(out_idx), 64'd6);
    check("long_end_count", {61'd0, count1}, 64'd0);
    check("long_end_bursts", {61'd0, bursts1}, 64'd0);

    // Simultaneous last push and last pop with count=2, bursts=1
    m1_ready = 1'b0;
    s1_valid = 1'b1; s1_tagid = 4'd10; s1_last = 1'b1;
    step();
    s1_tagid = 4'd11; s1_last = 1'b0;
    step();
    check("sim_pre_count", {61'd0, count1}, 64'd2);
    check("sim_pre_bursts", {61'd0, bursts1}, 64'd1);
    s1_tagid = 4'd12; s1_last = 1'b1; m1_ready = 1'b1;
    step();
    s1_valid = 1'b0; s1_last = 1'b0;
    check("sim_count", {61'd0, count1}, 64'd2);
    check("sim_bursts", {61'd0, bursts1}, 64'd1);
    check("sim_head", {60'd0, m1_tagid}, 64'd11);
    step(); step();
    check("sim_drain", {61'd0, count1}, 64'd0);
    m1_ready = 1'b0;

    // Async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      s0_valid = 1'b1; s0_tagid = 4'(i + 1); s0_last = (i == 1);
      step();
    end
    s0_valid = 1'b0; s0_last = 1'b0;
    check("mid_count", {61'd0, count0}, 64'd3);
    check("mid_bursts", {61'd0, bursts0}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", {63'd0, m0_valid}, 64'd0);
    check("arst_count", {61'd0, count0}, 64'd0);
    check("arst_bursts", {61'd0, bursts0}, 64'd0);
    check("arst_s_ready", {63'd0, s0_ready}, 64'd0);
    check("arst_tag", {60'd0, m0_tagid}, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("arst_release_ready", {63'd0, s0_ready}, 64'd1);
    check("arst_release_count", {61'd0, count0}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
